// File: rtl/filter_scheduler_pkg.sv
// Shared types and constants for the filter_scheduler debounce block.
// Build option FILTER_SCHED_SYNC_EN (see filter_scheduler.sv) adds input synchronisers.
package filter_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int HIST_DEF  = 3;
  localparam int DIV_W_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/filter_scheduler_if.sv
// Event port of filter_scheduler: valid/ready handshake carrying channel and level.
interface filter_scheduler_if #(
  parameter int N_CH = filter_pkg::N_CH_DEF
);
  localparam int CH_W = filter_pkg::clog2(N_CH);

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_level;

  modport master (output evt_valid, output evt_ch, output evt_level, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, input evt_level, output evt_ready);
endinterface

// File: rtl/filter_rr_arbiter.sv
// Round-robin picker over pending channel events; the grant is frozen while held
// and the search restarts just after the granted channel once it is accepted.
module filter_rr_arbiter
  import filter_pkg::*;
#(
  parameter  int N_CH = N_CH_DEF,
  localparam int CH_W = clog2(N_CH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] pending_i,
  input  logic            hold_i,
  input  logic            advance_i,
  output logic [CH_W-1:0] grant_o,
  output logic            valid_o
);

  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [CH_W-1:0] grant_q, grant_d;
  logic            valid_q, valid_d;
  logic [CH_W-1:0] pick;
  int              idx;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ptr_d = ptr_q;
    idx   = 0;
    if (advance_i) ptr_d = (int'(grant_q) == N_CH - 1) ? '0 : grant_q + 1'b1;
    pick = ptr_d;
    // Scanning downwards leaves the first pending channel at/after ptr_d in pick.
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = int'(ptr_d) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (pending_i[CH_W'(idx)]) pick = CH_W'(idx);
    end
    grant_d = hold_i ? grant_q : pick;
    valid_d = hold_i | (|pending_i);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  assign grant_o = grant_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/filter_scheduler.sv
// Time-multiplexed debounce/hysteresis for N_CH inputs with a round-robin event port.
// Define FILTER_SCHED_SYNC_EN to put a 2-flop synchroniser on every sig_in bit.
module filter_scheduler
  import filter_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int HIST  = HIST_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [DIV_W-1:0]   div_i,
  input  logic [N_CH-1:0]    sig_in_i,
  output logic [N_CH-1:0]    sig_out_o,
  output logic               evt_lost_o,
  output logic               busy_o,
  filter_scheduler_if.master evt
);

  localparam int CH_W = clog2(N_CH);

  state_e          state_q;
  logic [DIV_W-1:0] cnt_q, div_q;
  logic [CH_W-1:0] ch_q;
  logic [HIST-1:0] hist_q [N_CH];
  logic [N_CH-1:0] sig_out_q, pending_q, pending_d;
  logic            evt_lost_q, lost_d;
  logic [N_CH-1:0] sample, toggle, ack;
  logic [HIST-1:0] hist_new;
  logic [CH_W-1:0] arb_grant;
  logic            arb_valid;

`ifdef FILTER_SCHED_SYNC_EN
  logic [N_CH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sig_in_i;
      sync2_q <= sync1_q;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = sig_in_i;
`endif

  always_comb begin
    toggle   = '0;
    ack      = '0;
    hist_new = {hist_q[ch_q][HIST-2:0], sample[ch_q]};
    if (state_q == ST_SCAN) begin
      if (!sig_out_q[ch_q] && (&hist_new))  toggle[ch_q] = 1'b1;
      if (sig_out_q[ch_q]  && !(|hist_new)) toggle[ch_q] = 1'b1;
    end
    if (arb_valid && evt.evt_ready) ack[arb_grant] = 1'b1;
    // A toggle on the channel being accepted re-arms it instead of being lost.
    pending_d = (pending_q & ~ack) | toggle;
    lost_d    = |(toggle & pending_q & ~ack);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      ch_q       <= '0;
      sig_out_q  <= '0;
      pending_q  <= '0;
      evt_lost_q <= 1'b0;
      // NOTE: the history array is a handful of flops, not a RAM, and must come
      // out of reset cleared, so it is reset explicitly alongside the rest.
      for (int i = 0; i < N_CH; i++) hist_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cnt_q == div_q) begin
            cnt_q   <= '0;
            div_q   <= div_i;
            ch_q    <= '0;
            state_q <= ST_SCAN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_SCAN: begin
          hist_q[ch_q] <= hist_new;
          if (int'(ch_q) == N_CH - 1) state_q <= ST_IDLE;
          else                        ch_q    <= ch_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
      sig_out_q  <= sig_out_q ^ toggle;
      pending_q  <= pending_d;
      evt_lost_q <= lost_d;
    end
  end

  filter_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .clock     (clock),
    .reset     (reset),
    .pending_i (pending_d),
    .hold_i    (arb_valid & ~evt.evt_ready),
    .advance_i (arb_valid & evt.evt_ready),
    .grant_o   (arb_grant),
    .valid_o   (arb_valid)
  );

  assign evt.evt_valid = arb_valid;
  assign evt.evt_ch    = arb_grant;
  assign evt.evt_level = sig_out_q[arb_grant];
  assign sig_out_o     = sig_out_q;
  assign evt_lost_o    = evt_lost_q;
  assign busy_o        = (state_q == ST_SCAN);

endmodule

// File: tb/tb_filter_scheduler.sv
// Scoreboard bench for filter_scheduler (default build, N_CH=4, HIST=3, div=2).
module tb_filter_scheduler;

  localparam int N_CH = 4;

  typedef struct {
    int ch;
    int lvl;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [7:0]      div;
  logic [N_CH-1:0] sig_in;
  logic [N_CH-1:0] sig_out;
  logic            evt_lost;
  logic            busy;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   lost_cnt = 0;

  filter_scheduler_if #(.N_CH(N_CH)) evt ();

  filter_scheduler #(.N_CH(N_CH), .HIST(3), .DIV_W(8)) dut (
    .clock      (clk),
    .reset      (rst_n),
    .div_i      (div),
    .sig_in_i   (sig_in),
    .sig_out_o  (sig_out),
    .evt_lost_o (evt_lost),
    .busy_o     (busy),
    .evt        (evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted event.
  always @(negedge clk) begin
    exp_t e;
    if (evt_lost === 1'b1) lost_cnt++;
    if (rst_n && evt.evt_valid && evt.evt_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_evt_ch", int'(evt.evt_ch), 99);
      end else begin
        e = exp_q.pop_front();
        check("evt_ch", int'(evt.evt_ch), e.ch);
        check("evt_level", int'(evt.evt_level), e.lvl);
      end
    end
  end

  task automatic wait_scans(input int n);
    int seen = 0;
    int k = 0;
    logic prev = busy;
    while (seen < n && k < n * 64) begin
      @(negedge clk);
      k++;
      if (prev && !busy) seen++;
      prev = busy;
    end
    check("scans_completed", seen, n);
  endtask

  task automatic wait_sig(input int b, input logic v, output int scans);
    int k = 0;
    int found = 0;
    logic prev = busy;
    scans = 0;
    while (found == 0 && k < 200) begin
      @(negedge clk);
      k++;
      if (busy && !prev) scans++;
      prev = busy;
      if (sig_out[b] == v) found = 1;
    end
    check("sig_out_changed", found, 1);
  endtask

  task automatic wait_scan_start();
    int k = 0;
    while (!busy && k < 64) begin
      @(negedge clk);
      k++;
    end
    check("scan_started", int'(busy), 1);
  endtask

  task automatic accept_one(input int ch, input int lvl);
    int k = 0;
    exp_q.push_back('{ch: ch, lvl: lvl});
    while (!evt.evt_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("evt_valid_before_accept", int'(evt.evt_valid), 1);
    @(posedge clk); #1 evt.evt_ready = 1'b1;
    @(posedge clk); #1 evt.evt_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int scans;
    int bad;
    int lost0;
    int k;

    rst_n = 1'b0;
    div = 8'd2;
    sig_in = 4'b0001;
    evt.evt_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sig_out", int'(sig_out), 0);
    check("rst_evt_valid", int'(evt.evt_valid), 0);
    check("rst_evt_lost", int'(evt_lost), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;

    // ch0 rises on the third scan that samples it high
    wait_sig(0, 1'b1, scans);
    check("ch0_rise_scans", scans, 3);
    @(negedge clk);
    check("ch0_evt_valid", int'(evt.evt_valid), 1);
    check("ch0_evt_ch", int'(evt.evt_ch), 0);
    check("ch0_evt_level", int'(evt.evt_level), 1);
    accept_one(0, 1);
    check("ch0_evt_cleared", int'(evt.evt_valid), 0);

    // two-scan glitch on ch1 is filtered out
    wait_scans(1);
    sig_in = 4'b0011;
    wait_scans(2);
    sig_in = 4'b0001;
    wait_scans(3);
    check("glitch_sig_out", int'(sig_out), 1);
    check("glitch_no_evt", int'(evt.evt_valid), 0);

    // drop ch0 (ptr moves to 1), then raise ch0+ch2 with ready low
    sig_in = 4'b0000;
    wait_scans(3);
    check("ch0_fall_sig_out", int'(sig_out), 0);
    accept_one(0, 0);
    sig_in = 4'b0101;
    wait_scans(3);
    check("both_sig_out", int'(sig_out), 5);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!(evt.evt_valid && evt.evt_ch == 2'd0)) bad++;
    end
    check("lock_bad_cycles", bad, 0);
    exp_q.push_back('{ch: 0, lvl: 1});
    exp_q.push_back('{ch: 2, lvl: 1});
    @(posedge clk); #1 evt.evt_ready = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (evt.evt_valid && k < 20);
    evt.evt_ready = 1'b0;
    check("drain_done", int'(evt.evt_valid), 0);
    check("ptr_after_drain", int'(dut.u_arb.ptr_q), 3);

    // ch1 toggles twice without acceptance -> one lost pulse, level 0
    lost0 = lost_cnt;
    sig_in = 4'b0111;
    wait_scans(3);
    check("ch1_evt_ch", int'(evt.evt_ch), 1);
    sig_in = 4'b0101;
    wait_scans(3);
    check("lost_pulses", lost_cnt - lost0, 1);
    accept_one(1, 0);

    // ch3 accepted in the very cycle it toggles back low
    sig_in = 4'b1101;
    wait_scans(3);
    check("ch3_evt_ch", int'(evt.evt_ch), 3);
    sig_in = 4'b0101;
    wait_scans(2);
    lost0 = lost_cnt;
    wait_scan_start();
    exp_q.push_back('{ch: 3, lvl: 1});
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1 evt.evt_ready = 1'b1;
    @(posedge clk); #1 evt.evt_ready = 1'b0;
    @(negedge clk);
    check("ch3_rearm_valid", int'(evt.evt_valid), 1);
    check("ch3_rearm_ch", int'(evt.evt_ch), 3);
    check("ch3_rearm_level", int'(evt.evt_level), 0);
    @(negedge clk);
    check("ch3_no_lost", lost_cnt - lost0, 0);
    accept_one(3, 0);
    check("ch3_sig_out", int'(sig_out), 5);

    // ready without valid is ignored
    evt.evt_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (evt.evt_valid) bad++;
    end
    evt.evt_ready = 1'b0;
    check("idle_ready_valid", bad, 0);

    // reset mid-scan with events pending
    sig_in = 4'b0000;
    wait_scans(3);
    check("pre_rst_valid", int'(evt.evt_valid), 1);
    wait_scan_start();
    rst_n = 1'b0;
    #1;
    check("midrst_sig_out", int'(sig_out), 0);
    check("midrst_evt_valid", int'(evt.evt_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_evt_lost", int'(evt_lost), 0);
    sig_in = 4'b0010;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_sig(1, 1'b1, scans);
    check("post_rst_rise_scans", scans, 3);
    accept_one(1, 1);
    check("post_rst_sig_out", int'(sig_out), 2);
    check("scoreboard_empty", exp_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/filter_scheduler.md
Name: filter_scheduler

Overview:
- Time-multiplexed debounce/hysteresis controller for N_CH noisy inputs; one shared evaluation slot visits the channels round-robin on each prescaled sample tick.
- Per channel: a sample-history shift register and a hysteretic output. Output sets after HIST consecutive 1 samples and clears after HIST consecutive 0 samples.
- Output transitions are queued as per-channel pending events and drained through a round-robin valid/ready event port.
- Sits between raw pad inputs and the control logic that consumes clean levels and edge events.

Parameters:
- N_CH, 4, number of input channels (2..16).
- HIST, 3, consecutive equal samples needed to change a channel output (2..8).
- DIV_W, 8, width of the prescaler divide value.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- div  in  DIV_W  sample period minus one, in idle cycles; sampled when the prescaler reloads.
- sig_in  in  N_CH  raw asynchronous inputs.
- sig_out  out  N_CH  filtered levels, registered.
- evt_valid  out  1  an event is presented.
- evt_ready  in  1  consumer accepts the event.
- evt_ch  out  clog2(N_CH)  channel of the presented event.
- evt_level  out  1  current sig_out of evt_ch.
- evt_lost  out  1  one-cycle pulse: a toggle hit a channel whose event was still pending.
- busy  out  1  FSM is in SCAN.

Behaviour:
- Reset (asynchronous, reset=0):
  - sig_out, all histories, pending bits, evt_valid and evt_lost = 0.
  - Prescaler count = 0; round-robin pointer = 0; FSM = IDLE.
- Prescaler:
  - Counts only in IDLE. When the count equals div, it reloads to 0 and the FSM enters SCAN next cycle.
  - div=0 gives a tick on every IDLE cycle.
  - Resulting sample period is div+1+N_CH cycles.
- FSM states: IDLE and SCAN.
  - SCAN visits ch = 0..N_CH-1, one channel per cycle, then returns to IDLE.
  - Visiting ch shifts the current sample into hist[ch] (HIST bits, newest at bit 0).
  - Set rule: sig_out[ch]=0 and the new hist is all ones -> sig_out[ch]=1 and pending[ch]=1.
  - Clear rule: sig_out[ch]=1 and the new hist is all zeros -> sig_out[ch]=0 and pending[ch]=1.
  - Otherwise sig_out[ch] holds (hysteresis).
  - sig_out updates one cycle after the visit cycle.
  - busy = 1 throughout SCAN.
- Latency: a clean input change appears on sig_out after HIST ticks, plus 2 cycles when SYNC is on.
- Event port (AXI-style):
  - evt_valid = any pending bit set, registered.
  - When no event is held, the arbiter picks the first pending channel at or after the pointer.
  - evt_ch is locked while evt_valid=1 and evt_ready=0.
  - Handshake (valid & ready) clears pending[evt_ch] and moves the pointer to evt_ch+1, wrapping at N_CH.
  - A new selection is presented the next cycle.
  - evt_level always tracks sig_out[evt_ch].
- Simultaneous and boundary cases:
  - Toggle on the handshaked channel in the same cycle: pending stays 1, no evt_lost.
  - Toggle while pending=1 with no handshake: pending stays 1 and evt_lost pulses.
  - evt_ready high while evt_valid=0: ignored.
  - div change mid-count: takes effect at the next reload.
  - Reset mid-SCAN: immediate return to reset state. Partial scan results are discarded.

Optional Feature:
- Macro FILTER_SCHED_SYNC_EN.
  - Defined: each sig_in bit passes through a 2-flop synchroniser (reset 0) before sampling.
  - Undefined: sig_in is sampled directly and the latency drops by 2 cycles.

Decomposition:
- Package filter_pkg holds:
  - FSM state encoding (ST_IDLE, ST_SCAN).
  - Default N_CH/HIST/DIV_W constants.
  - clog2 helper function.
- Sub-module filter_rr_arbiter: N_CH-wide round-robin pick with lock/hold.
  - Inputs: pending, hold, advance.
  - Outputs: grant index and valid.

Test Plan:
- Reset, then div=2, sig_in=4'b0001 held -> sig_out[0] rises after 3 scans (about 21 cycles, SYNC on); evt_valid=1, evt_ch=0, evt_level=1; handshake clears it.
- Pulse sig_in[1] high for 2 ticks only (HIST=3) -> sig_out[1] stays 0; no event.
- Raise ch0 and ch2 together, evt_ready=0 for 50 cycles -> evt_ch=0 stays locked. Then ready=1 -> ch0 accepted, then ch2, pointer=3.
- Toggle ch1 high, then back low, with no acceptance in between -> evt_lost pulses once; evt_level=0 at acceptance.
- Handshake on ch3 in the same cycle ch3 toggles -> pending[3] remains set; evt_valid re-asserts with ch3; evt_lost=0.
- Assert reset during SCAN with pending bits set -> all outputs 0 immediately, busy=0; operation resumes cleanly after release.
